// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, next-PC select encodings, the NOP word
// and the fetch state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_JMP = 4'hB;
    localparam logic [3:0] OP_NOP = 4'hC;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_DIRECT = 2'b01;
    localparam logic [1:0] PC_INC    = 2'b10;

    localparam logic [15:0] NOP_INSTR = {OP_NOP, 12'h000};

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, runs the strobe/ack imem read and holds the IR.
// Define FETCH_TIMEOUT_EN to abandon fetches that see no ack within TIMEOUT cycles.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_mux,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] imem_adr_o,
    output logic              imem_stb_o,
    input  logic [15:0]       imem_dat_i,
    input  logic              imem_ack_i,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_err
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir;
    logic              valid_q;
    logic              stb_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
`endif

    // IR is forced to NOP whenever a fetch is outstanding, so instr never shows a stale word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            ir      <= NOP_INSTR;
            valid_q <= 1'b0;
            stb_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir      <= imem_dat_i;
                        valid_q <= 1'b1;
                        stb_q   <= 1'b0;
                        state   <= EXEC;
`ifdef FETCH_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        ir      <= NOP_INSTR;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        stb_q   <= 1'b0;
                        state   <= EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                EXEC: begin
                    if (pc_mux != PC_HOLD) begin
                        pc_q    <= (pc_mux == PC_DIRECT) ? pc_target : pc_q + ADDR_W'(1);
                        ir      <= NOP_INSTR;
                        valid_q <= 1'b0;
                        stb_q   <= 1'b1;
                        state   <= FETCH;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imem_adr_o  = pc_q;
    assign imem_stb_o  = stb_q;
    assign instr       = ir;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetch/exec vectors with a scoreboard,
// plus hand-written reset and (with FETCH_TIMEOUT_EN) timeout sequences.
module tb_instr_fetch;

    localparam int          ADDR_W   = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          TIMEOUT  = 15;
    localparam logic [15:0] NOP      = 16'hC000;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        pc_mux;
    logic [ADDR_W-1:0] pc_target;
    logic [ADDR_W-1:0] imem_adr_o;
    logic              imem_stb_o;
    logic [15:0]       imem_dat_i;
    logic              imem_ack_i;
    logic [15:0]       instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              fetch_err;

    typedef struct {
        logic [15:0] exp_adr;
        logic [15:0] data;
        int          delay;
        int          hold;
        bit          spurious;
        logic [1:0]  mux;
        logic [15:0] target;
    } vec_t;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_mux      (pc_mux),
        .pc_target   (pc_target),
        .imem_adr_o  (imem_adr_o),
        .imem_stb_o  (imem_stb_o),
        .imem_dat_i  (imem_dat_i),
        .imem_ack_i  (imem_ack_i),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitFetch();
        int i;
        for (i = 0; i < 20 && imem_stb_o !== 1'b1; i++) tick();
        checkOutput("stb_seen", {31'b0, imem_stb_o}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        waitFetch();
        checkOutput("fetch_adr", imem_adr_o, v.exp_adr);
        for (int d = 0; d < v.delay; d++) begin
            checkOutput("wait_stb", imem_stb_o, 1);
            checkOutput("wait_adr", imem_adr_o, v.exp_adr);
            checkOutput("wait_instr", instr, NOP);
            checkOutput("wait_valid", instr_valid, 0);
            tick();
        end
        imem_ack_i = 1'b1;
        imem_dat_i = v.data;
        sb.push_back('{instr: v.data, pc: v.exp_adr});
        tick();
        imem_ack_i = 1'b0;
        imem_dat_i = 16'h0000;
        checkOutput("sb_nonempty", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("exec_instr", instr, e.instr);
            checkOutput("exec_pc", pc, e.pc);
            checkOutput("exec_valid", instr_valid, 1);
            checkOutput("exec_stb", imem_stb_o, 0);
            for (int h = 0; h < v.hold; h++) begin
                pc_mux = 2'b00;
                if (v.spurious) begin
                    imem_ack_i = 1'b1;
                    imem_dat_i = 16'hDEAD;
                end
                tick();
                imem_ack_i = 1'b0;
                checkOutput("hold_instr", instr, e.instr);
                checkOutput("hold_pc", pc, e.pc);
                checkOutput("hold_stb", imem_stb_o, 0);
                checkOutput("hold_valid", instr_valid, 1);
            end
        end
        pc_mux    = v.mux;
        pc_target = v.target;
        tick();
        pc_mux    = 2'b00;
        pc_target = 16'h0000;
    endtask

    initial begin
        vecs[0] = '{exp_adr: 16'h0000, data: 16'h0123, delay: 0, hold: 0, spurious: 0, mux: 2'b10, target: 16'h0000};
        vecs[1] = '{exp_adr: 16'h0001, data: 16'h1111, delay: 3, hold: 5, spurious: 1, mux: 2'b01, target: 16'h00F0};
        vecs[2] = '{exp_adr: 16'h00F0, data: 16'h2222, delay: 1, hold: 0, spurious: 0, mux: 2'b11, target: 16'h1234};
        vecs[3] = '{exp_adr: 16'h00F1, data: 16'h3333, delay: 0, hold: 0, spurious: 0, mux: 2'b01, target: 16'hFFFF};
        vecs[4] = '{exp_adr: 16'hFFFF, data: 16'h4444, delay: 2, hold: 1, spurious: 0, mux: 2'b10, target: 16'h5555};
        vecs[5] = '{exp_adr: 16'h0000, data: 16'h5555, delay: 0, hold: 2, spurious: 1, mux: 2'b10, target: 16'h0000};

        rst        = 1'b1;
        pc_mux     = 2'b00;
        pc_target  = 16'h0000;
        imem_dat_i = 16'h0000;
        imem_ack_i = 1'b0;
        tick();
        tick();
        checkOutput("rst_stb", imem_stb_o, 0);
        checkOutput("rst_valid", instr_valid, 0);
        checkOutput("rst_instr", instr, NOP);
        checkOutput("rst_pc", pc, RESET_PC);
        checkOutput("rst_err", fetch_err, 0);
        rst = 1'b0;
        tick();
        checkOutput("stb_after_rst", imem_stb_o, 1);

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Reset while a fetch is pending and acked in the same cycle.
        checkOutput("pre_rst_adr", imem_adr_o, 16'h0001);
        checkOutput("pre_rst_stb", imem_stb_o, 1);
        rst        = 1'b1;
        imem_ack_i = 1'b1;
        imem_dat_i = 16'hBEEF;
        tick();
        rst        = 1'b0;
        imem_ack_i = 1'b0;
        checkOutput("midrst_stb", imem_stb_o, 0);
        checkOutput("midrst_instr", instr, NOP);
        checkOutput("midrst_valid", instr_valid, 0);
        checkOutput("midrst_pc", pc, RESET_PC);
        tick();
        checkOutput("refetch_stb", imem_stb_o, 1);
        checkOutput("refetch_adr", imem_adr_o, RESET_PC);
        imem_ack_i = 1'b1;
        imem_dat_i = 16'h0777;
        tick();
        imem_ack_i = 1'b0;
        checkOutput("refetch_instr", instr, 16'h0777);

        // Reset in EXEC discards the pending pc_mux.
        pc_mux = 2'b10;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        pc_mux = 2'b00;
        checkOutput("execrst_pc", pc, RESET_PC);
        checkOutput("execrst_valid", instr_valid, 0);
        checkOutput("execrst_instr", instr, NOP);

`ifdef FETCH_TIMEOUT_EN
        waitFetch();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            checkOutput("to_wait_err", fetch_err, 0);
            checkOutput("to_wait_valid", instr_valid, 0);
        end
        tick();
        checkOutput("to_err", fetch_err, 1);
        checkOutput("to_valid", instr_valid, 1);
        checkOutput("to_instr", instr, NOP);
        checkOutput("to_stb", imem_stb_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("to_sticky", fetch_err, 1);
            checkOutput("to_hold_instr", instr, NOP);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("to_rst_err", fetch_err, 0);
`else
        waitFetch();
        for (int i = 0; i < 20; i++) tick();
        checkOutput("noto_stb", imem_stb_o, 1);
        checkOutput("noto_err", fetch_err, 0);
        checkOutput("noto_valid", instr_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
